// File: rtl/vga_color_reducer.sv
// VGA colour output stage: narrows 8-bit channels to board DAC widths with 4x4 ordered dithering,
// blanks outside active video and keeps syncs aligned (2-cycle latency). Define VGA_DITHER_EN to enable dithering.
module vga_color_reducer #(
  parameter int IN_BITS         = 8,
  parameter int R_BITS          = 3,
  parameter int G_BITS          = 3,
  parameter int B_BITS          = 2,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int TEMPORAL        = 0
) (
  input  logic               CLK_25MHZ,
  input  logic               RESET_N,
  input  logic               VGA_HSYNC_IN,
  input  logic               VGA_VSYNC_IN,
  input  logic               VGA_DE_IN,
  input  logic [IN_BITS-1:0] VGA_RED_IN,
  input  logic [IN_BITS-1:0] VGA_GREEN_IN,
  input  logic [IN_BITS-1:0] VGA_BLUE_IN,
  output logic               VGA_HSYNC,
  output logic               VGA_VSYNC,
  output logic [R_BITS-1:0]  VGA_RED,
  output logic [G_BITS-1:0]  VGA_GREEN,
  output logic [B_BITS-1:0]  VGA_BLUE
);

  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam int   DR = IN_BITS - R_BITS;
  localparam int   DG = IN_BITS - G_BITS;
  localparam int   DB = IN_BITS - B_BITS;

  logic [3:0] t_raw;
  logic       odd_frame;
  logic [3:0] t;

`ifdef VGA_DITHER_EN
  localparam logic [3:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  logic [1:0] x_q;
  logic [1:0] y_q;
  logic       parity_q;
  logic       de_d_q;
  logic       vs_act_d_q;
  logic       vs_act;

  assign vs_act = (SYNC_ACTIVE_LOW != 0) ? ~VGA_VSYNC_IN : VGA_VSYNC_IN;

  // A vsync activation clears y even when a DE falling edge lands on the same cycle.
  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      x_q        <= 2'd0;
      y_q        <= 2'd0;
      parity_q   <= 1'b0;
      de_d_q     <= 1'b0;
      vs_act_d_q <= 1'b0;
    end else begin
      de_d_q     <= VGA_DE_IN;
      vs_act_d_q <= vs_act;
      x_q        <= VGA_DE_IN ? x_q + 2'd1 : 2'd0;
      if (vs_act && !vs_act_d_q) begin
        y_q      <= 2'd0;
        parity_q <= ~parity_q;
      end else if (de_d_q && !VGA_DE_IN) begin
        y_q <= y_q + 2'd1;
      end
    end
  end

  assign t_raw     = BAYER[{y_q, x_q}];
  assign odd_frame = parity_q;
`else
  assign t_raw     = 4'd0;
  assign odd_frame = 1'b0;
`endif

  assign t = ((TEMPORAL != 0) && odd_frame) ? ~t_raw : t_raw;

  // Align the 0..15 threshold with the bits that are about to be dropped.
  function automatic logic [IN_BITS-1:0] scale_t(input logic [3:0] thr, input int d);
    logic [IN_BITS+3:0] w;
    w = {{IN_BITS{1'b0}}, thr};
    if (d == 0)      w = '0;
    else if (d >= 4) w = w << (d - 4);
    else             w = w >> (4 - d);
    return IN_BITS'(w);
  endfunction

  function automatic logic [IN_BITS-1:0] sat_add(input logic [IN_BITS-1:0] a,
                                                 input logic [IN_BITS-1:0] b);
    logic [IN_BITS:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[IN_BITS] ? {IN_BITS{1'b1}} : sum[IN_BITS-1:0];
  endfunction

  logic [IN_BITS-1:0] r1_q, g1_q, b1_q;
  logic               de1_q, hs1_q, vs1_q;

  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      r1_q  <= '0;
      g1_q  <= '0;
      b1_q  <= '0;
      de1_q <= 1'b0;
      hs1_q <= SYNC_IDLE;
      vs1_q <= SYNC_IDLE;
    end else begin
      r1_q  <= sat_add(VGA_RED_IN,   scale_t(t, DR));
      g1_q  <= sat_add(VGA_GREEN_IN, scale_t(t, DG));
      b1_q  <= sat_add(VGA_BLUE_IN,  scale_t(t, DB));
      de1_q <= VGA_DE_IN;
      hs1_q <= VGA_HSYNC_IN;
      vs1_q <= VGA_VSYNC_IN;
    end
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      VGA_RED   <= '0;
      VGA_GREEN <= '0;
      VGA_BLUE  <= '0;
      VGA_HSYNC <= SYNC_IDLE;
      VGA_VSYNC <= SYNC_IDLE;
    end else begin
      VGA_RED   <= de1_q ? R_BITS'(r1_q >> DR) : '0;
      VGA_GREEN <= de1_q ? G_BITS'(g1_q >> DG) : '0;
      VGA_BLUE  <= de1_q ? B_BITS'(b1_q >> DB) : '0;
      VGA_HSYNC <= hs1_q;
      VGA_VSYNC <= vs1_q;
    end
  end

endmodule

// File: tb/tb_vga_color_reducer.sv
// Directed bench for vga_color_reducer: default 3/3/2, 8/8/8 passthrough and TEMPORAL=1 instances
// share one stimulus stream; each pixel's expected outputs are queued and checked two edges later.
module tb_vga_color_reducer;

`ifdef VGA_DITHER_EN
  localparam bit DITH = 1'b1;
`else
  localparam bit DITH = 1'b0;
`endif
  localparam int EW = 37;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       de_in, hs_in, vs_in;
  logic [7:0] r_in, g_in, b_in;

  logic       hs_o, vs_o;
  logic [2:0] r_o, g_o;
  logic [1:0] b_o;
  logic       pt_hs, pt_vs;
  logic [7:0] pt_r, pt_g, pt_b;
  logic       tm_hs, tm_vs;
  logic [2:0] tm_r, tm_g;
  logic [1:0] tm_b;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int step = 0;
  bit count_red = 1'b0;
  int red3_seen = 0;

  always #20 clk = ~clk;

  vga_color_reducer dut (
    .CLK_25MHZ(clk), .RESET_N(rst_n),
    .VGA_HSYNC_IN(hs_in), .VGA_VSYNC_IN(vs_in), .VGA_DE_IN(de_in),
    .VGA_RED_IN(r_in), .VGA_GREEN_IN(g_in), .VGA_BLUE_IN(b_in),
    .VGA_HSYNC(hs_o), .VGA_VSYNC(vs_o),
    .VGA_RED(r_o), .VGA_GREEN(g_o), .VGA_BLUE(b_o)
  );

  vga_color_reducer #(.R_BITS(8), .G_BITS(8), .B_BITS(8)) dut_pt (
    .CLK_25MHZ(clk), .RESET_N(rst_n),
    .VGA_HSYNC_IN(hs_in), .VGA_VSYNC_IN(vs_in), .VGA_DE_IN(de_in),
    .VGA_RED_IN(r_in), .VGA_GREEN_IN(g_in), .VGA_BLUE_IN(b_in),
    .VGA_HSYNC(pt_hs), .VGA_VSYNC(pt_vs),
    .VGA_RED(pt_r), .VGA_GREEN(pt_g), .VGA_BLUE(pt_b)
  );

  vga_color_reducer #(.TEMPORAL(1)) dut_tm (
    .CLK_25MHZ(clk), .RESET_N(rst_n),
    .VGA_HSYNC_IN(hs_in), .VGA_VSYNC_IN(vs_in), .VGA_DE_IN(de_in),
    .VGA_RED_IN(r_in), .VGA_GREEN_IN(g_in), .VGA_BLUE_IN(b_in),
    .VGA_HSYNC(tm_hs), .VGA_VSYNC(tm_vs),
    .VGA_RED(tm_r), .VGA_GREEN(tm_g), .VGA_BLUE(tm_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    step++;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s @step %0d: observed %0h expected %0h", tag, step, obs, exp_v);
    end
  endtask

  // Red for 0x50 (any row) and 0x5A (row 0): the threshold crosses into code 3 on a checkerboard,
  // and an odd temporal frame swaps the two phases.
  function automatic logic [2:0] red_dith(input int x, input int y, input bit inv);
    return (DITH && ((((x + y) % 2) == 1) != inv)) ? 3'd3 : 3'd2;
  endfunction

  task automatic drive(input logic de, input logic hs, input logic vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [2:0] er, input logic [2:0] eg, input logic [1:0] eb,
                       input logic [2:0] etr);
    logic [EW-1:0] e;
    de_in = de; hs_in = hs; vs_in = vs;
    r_in = r; g_in = g; b_in = b;
    tick();
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("hsync",     8'(hs_o),  8'(e[36]));
      check("vsync",     8'(vs_o),  8'(e[35]));
      check("red",       8'(r_o),   8'(e[34:32]));
      check("green",     8'(g_o),   8'(e[31:29]));
      check("blue",      8'(b_o),   8'(e[28:27]));
      check("pt_hsync",  8'(pt_hs), 8'(e[36]));
      check("pt_vsync",  8'(pt_vs), 8'(e[35]));
      check("pt_red",    pt_r,      e[26:19]);
      check("pt_green",  pt_g,      e[18:11]);
      check("pt_blue",   pt_b,      e[10:3]);
      check("tm_hsync",  8'(tm_hs), 8'(e[36]));
      check("tm_vsync",  8'(tm_vs), 8'(e[35]));
      check("tm_red",    8'(tm_r),  8'(e[2:0]));
      check("tm_green",  8'(tm_g),  8'(e[31:29]));
      check("tm_blue",   8'(tm_b),  8'(e[28:27]));
      if (count_red && r_o == 3'd3) red3_seen++;
    end
    if (de) exp_q.push_back({hs, vs, er, eg, eb, r, g, b, etr});
    else    exp_q.push_back({hs, vs, 35'd0});
  endtask

  initial begin
    rst_n = 1'b0;
    de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    r_in = 8'h00; g_in = 8'h00; b_in = 8'h00;

    // Reset held for 4 edges with random inputs: black, inactive (high) syncs.
    for (int i = 0; i < 4; i++) begin
      de_in = 1'($urandom_range(0, 1));
      hs_in = 1'($urandom_range(0, 1));
      vs_in = 1'($urandom_range(0, 1));
      r_in  = 8'($urandom_range(0, 255));
      g_in  = 8'($urandom_range(0, 255));
      b_in  = 8'($urandom_range(0, 255));
      tick();
      check("rst_red",   8'(r_o),   8'd0);
      check("rst_green", 8'(g_o),   8'd0);
      check("rst_blue",  8'(b_o),   8'd0);
      check("rst_hsync", 8'(hs_o),  8'd1);
      check("rst_vsync", 8'(vs_o),  8'd1);
      check("rst_pt_red", pt_r,     8'd0);
      check("rst_tm_red", 8'(tm_r), 8'd0);
      check("rst_tm_vsync", 8'(tm_vs), 8'd1);
    end

    // Release: stage 1 still holds reset contents, so the first output after release is idle.
    rst_n = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 35'd0});

    // Blanking with white input and an hsync pulse.
    drive(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd0, 2'd0, 3'd0);
    drive(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd0, 2'd0, 3'd0);
    drive(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd0, 2'd0, 3'd0);
    drive(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd0, 2'd0, 3'd0);

    // Dither: red 0x50 across a 4x4 block, frame 0.
    count_red = 1'b1;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++)
        drive(1'b1, 1'b1, 1'b1, 8'h50, 8'h00, 8'h00,
              red_dith(x, y, 1'b0), 3'd0, 2'd0, red_dith(x, y, 1'b0));
      drive(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd0, 2'd0, 3'd0);
    end
    count_red = 1'b0;
    check("red3_count", 8'(red3_seen), DITH ? 8'd8 : 8'd0);

    // Saturation: white over a full 4x4 block must never wrap.
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++)
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 3'd7, 3'd7, 2'd3, 3'd7);
      drive(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd0, 2'd0, 3'd0);
    end

    // Passthrough pattern on row 0: 0xA5 green stays 5, 0x01 blue stays 0 on the reduced board.
    for (int x = 0; x < 4; x++)
      drive(1'b1, 1'b1, 1'b1, 8'h5A, 8'hA5, 8'h01,
            red_dith(x, 0, 1'b0), 3'd5, 2'd0, red_dith(x, 0, 1'b0));

    // DE falls on the same cycle vsync activates: y must return to 0, frame becomes odd.
    drive(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd0, 2'd0, 3'd0);
    drive(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd0, 2'd0, 3'd0);

    // Frame 1, row 0: the temporal instance uses the inverted pattern.
    for (int x = 0; x < 4; x++)
      drive(1'b1, 1'b1, 1'b1, 8'h50, 8'h00, 8'h00,
            red_dith(x, 0, 1'b0), 3'd0, 2'd0, red_dith(x, 0, 1'b1));
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 2'd0, 3'd0);
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 2'd0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_color_reducer.md
# vga_color_reducer

Parametrised VGA colour output stage between the video core and the board pins. It narrows each 8-bit colour channel to the DAC width of a given board, using 4x4 ordered (Bayer) dithering instead of plain bit truncation. It delays HSYNC/VSYNC by the same pipeline latency as the colour path and forces black during blanking. It replaces hard-coded top-level slicing, so one block serves 3/3/2, 4/4/4 and 5/6/5 boards.

## Interface
- IN_BITS, 8, input channel width.
- R_BITS, 3, red output width, 1..IN_BITS.
- G_BITS, 3, green output width, 1..IN_BITS.
- B_BITS, 2, blue output width, 1..IN_BITS.
- SYNC_ACTIVE_LOW, 1, sync polarity of the input and output syncs (1 = active-low).
- TEMPORAL, 0, 1 = invert the threshold pattern on odd frames.

Ports:
- CLK_25MHZ  in  1  pixel clock; the block's only clock.
- RESET_N  in  1  reset; synchronous, active-low.
- VGA_HSYNC_IN, VGA_VSYNC_IN  in  1 each  syncs from the core.
- VGA_DE_IN  in  1  active-video enable.
- VGA_RED_IN, VGA_GREEN_IN, VGA_BLUE_IN  in  IN_BITS each  full-width colour.
- VGA_HSYNC, VGA_VSYNC  out  1 each  delayed syncs.
- VGA_RED  out  R_BITS  reduced red.
- VGA_GREEN  out  G_BITS  reduced green.
- VGA_BLUE  out  B_BITS  reduced blue.

## Operation
- Position counters (2-bit x, 2-bit y):
  - x increments on every cycle with VGA_DE_IN=1 and wraps 3→0. It clears to 0 on any cycle with DE=0.
  - y increments on each DE falling edge and wraps 3→0. It clears to 0 on the cycle VSYNC_IN becomes active.
- Frame parity toggles on each VSYNC_IN activation edge. It is used only when TEMPORAL=1.
- Threshold t is Bayer[y][x], 0..15, with these rows:
  - y=0: 0 8 2 10
  - y=1: 12 4 14 6
  - y=2: 3 11 1 9
  - y=3: 15 7 13 5
- With TEMPORAL=1 on an odd frame, t becomes 15−t.
- Per channel, let D = IN_BITS − W_out.
  - Scaled threshold s = t<<(D−4) if D≥4, else t>>(4−D).
  - If D=0, s=0 and the channel passes through unchanged.
- Sum = in + s, computed at IN_BITS+1 bits.
  - If the carry bit is set, saturate to all ones (IN_BITS wide).
  - Output = top W_out bits of the saturated sum.
- Blanking: if DE was 0 at input, all colour outputs are 0 at the matching output cycle.
- Syncs pass through unchanged in value, delayed to stay aligned with colour.

## Timing
- Latency is 2 cycles for colour, syncs and blanking alike.
  - Stage 1 registers the saturated sums, DE and the syncs.
  - Stage 2 registers the truncated outputs, the blank mask and the syncs.
- Throughput is one pixel per clock. There is no back-pressure and no stall.
- Reset (RESET_N=0 at a rising edge):
  - All colour outputs are 0.
  - VGA_HSYNC and VGA_VSYNC go to the inactive level: 1 if SYNC_ACTIVE_LOW, else 0.
  - x, y and frame parity are 0. The pipeline valid/DE stages are 0.
- Reset mid-line: the first 2 cycles after release output black with inactive syncs. The counters start at 0 on the first DE=1 cycle.
- Simultaneous VSYNC activation and DE falling edge in the same cycle: the y clear wins, so y=0.
- DE=1 while VSYNC is active: the counters still run. This is not legal VGA, so no special handling is required.

## Configuration
- VGA_DITHER_EN:
  - Defined: dithering as described above.
  - Undefined: s=0 for all channels. The x/y counters, frame parity and Bayer logic are compiled out, leaving pure truncation plus the 2-cycle sync/blank alignment. Latency and reset values are unchanged.

## Test plan
- Reset: hold RESET_N=0 for 4 cycles with random inputs.
  - Required: RGB=0 and syncs=1 (active-low) throughout.
  - Required: the first non-reset output appears exactly 2 cycles after release.
- Dither, default widths: RED_IN=0x50 held for a 4x4 block.
  - Required: at (x=0, y=0), t=0 gives VGA_RED=2.
  - Required: at (x=0, y=3), t=15 and s=30 give 110, so VGA_RED=3.
  - Required: 8 of 16 pixels output 3.
- Saturation: all channels 0xFF over a full 4x4 block.
  - Required: R=7, G=7, B=3 at every position, with no wrap to 0.
- Blanking and alignment: DE low with RGB=0xFF and an HSYNC pulse.
  - Required: RGB=0 and the HSYNC output pulse lag the input by exactly 2 cycles each.
- Passthrough: R_BITS=G_BITS=B_BITS=8, inputs 0x5A, 0xA5, 0x01.
  - Required: identical values out, 2 cycles later, at every position.
- TEMPORAL=1: RED_IN=0x50 at (x=0, y=0) on frames 0 and 1.
  - Required: VGA_RED=2 on frame 0, then 3 on frame 1 (t=15).
  - With VGA_DITHER_EN undefined: 2 on both frames.
